sort_engine: RTL and testbench

SORT_ENGINE -- requirements
Module: sort_engine

---
 rtl/sort_engine.sv | 171 +++++++++++++++++
 tb/tb_sort_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// In-place selection sort over a small register-file buffer.
// Host loads/reads the buffer while idle; start sorts it in place.
module sort_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SIGNED = 0,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             desc,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  output logic             ready,
  output logic             done,
  output logic [AW:0]      swaps
);

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, OUTER, INNER, CHECK, SWAP_A, SWAP_B
  } state_t;

  state_t state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] mi;
  logic [AW:0]      i;
  logic [AW:0]      j;
  logic [AW:0]      jm;
  logic [AW:0]      jn;
  logic             desc_q;

  logic             we;
  logic             rd_en;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] wdata;
  logic             lt;
  logic             gt;
  logic             better;

  assign dataout = rd_q;
  assign jn = j + 1'b1;

  // Candidate in rd_q beats the current extreme m (strict, so ties keep lowest index)
  always_comb begin
    if (SIGNED != 0) begin
      lt = $signed(rd_q) < $signed(m);
      gt = $signed(rd_q) > $signed(m);
    end else begin
      lt = rd_q < m;
      gt = rd_q > m;
    end
    better = desc_q ? gt : lt;
  end

  // Single read and single write port steering: host while idle, sorter otherwise
  always_comb begin
    we    = 1'b0;
    rd_en = 1'b0;
    waddr = addr;
    wdata = datain;
    raddr = addr;
    unique case (state)
      IDLE: begin
        we    = wr & ~start;
        rd_en = ~wr & ~start;
      end
      OUTER: begin
        raddr = i[AW-1:0];
        rd_en = 1'b1;
      end
      INNER: begin
        raddr = (j == LAST) ? j[AW-1:0] : jn[AW-1:0];
        rd_en = 1'b1;
      end
      SWAP_A: begin
        we    = 1'b1;
        waddr = i[AW-1:0];
        wdata = m;
      end
      SWAP_B: begin
        we    = 1'b1;
        waddr = jm[AW-1:0];
        wdata = mi;
      end
      default: ;
    endcase
  end

  // Buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Sort sequencer; rd_q holds the element at index j while in INNER
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      swaps  <= '0;
      rd_q   <= '0;
      m      <= '0;
      mi     <= '0;
      i      <= '0;
      j      <= '0;
      jm     <= '0;
      desc_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_en) rd_q <= mem[raddr];
      unique case (state)
        IDLE: begin
          if (start) begin
            desc_q <= desc;
            swaps  <= '0;
            i      <= '0;
            ready  <= 1'b0;
            state  <= OUTER;
          end
        end
        OUTER: begin
          if (i == LAST) begin
            ready <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            j     <= i;
            jm    <= i;
            state <= INNER;
          end
        end
        INNER: begin
          if (j == i) begin
            m  <= rd_q;
            mi <= rd_q;
          end else if (better) begin
            m  <= rd_q;
            jm <= j;
          end
          if (j == LAST) state <= CHECK;
          else j <= jn;
        end
        CHECK: begin
          if (jm == i) begin
            i     <= i + 1'b1;
            state <= OUTER;
          end else begin
            state <= SWAP_A;
          end
        end
        SWAP_A: state <= SWAP_B;
        SWAP_B: begin
          swaps <= swaps + 1'b1;
          i     <= i + 1'b1;
          state <= OUTER;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: four instances (unsigned 8, signed 8,
// depth 5, depth 2) driven from shared host signals, one selected at a time.
module tb_sort_engine;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       desc = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] datain = '0;
  int         sel = 0;
  int         total = 0;
  int         bad = 0;

  logic [7:0] d0, d1, d2, d3;
  logic       r0, r1, r2, r3;
  logic       n0, n1, n2, n3;
  logic [3:0] s0, s1, s2;
  logic [1:0] s3;
  logic [7:0] dout_c;
  logic       ready_c;
  logic       done_c;
  logic [3:0] swaps_c;

  always #5 clk = ~clk;

  sort_engine #(.WIDTH(8), .DEPTH(8), .SIGNED(0)) u0 (
    .clk(clk), .nrst(nrst), .start(start && sel == 0), .desc(desc),
    .wr(wr && sel == 0), .addr(addr), .datain(datain),
    .dataout(d0), .ready(r0), .done(n0), .swaps(s0));
  sort_engine #(.WIDTH(8), .DEPTH(8), .SIGNED(1)) u1 (
    .clk(clk), .nrst(nrst), .start(start && sel == 1), .desc(desc),
    .wr(wr && sel == 1), .addr(addr), .datain(datain),
    .dataout(d1), .ready(r1), .done(n1), .swaps(s1));
  sort_engine #(.WIDTH(8), .DEPTH(5), .SIGNED(0)) u2 (
    .clk(clk), .nrst(nrst), .start(start && sel == 2), .desc(desc),
    .wr(wr && sel == 2), .addr(addr), .datain(datain),
    .dataout(d2), .ready(r2), .done(n2), .swaps(s2));
  sort_engine #(.WIDTH(8), .DEPTH(2), .SIGNED(0)) u3 (
    .clk(clk), .nrst(nrst), .start(start && sel == 3), .desc(desc),
    .wr(wr && sel == 3), .addr(addr[0:0]), .datain(datain),
    .dataout(d3), .ready(r3), .done(n3), .swaps(s3));

  always_comb begin
    dout_c = d0; ready_c = r0; done_c = n0; swaps_c = s0;
    case (sel)
      1: begin dout_c = d1; ready_c = r1; done_c = n1; swaps_c = s1; end
      2: begin dout_c = d2; ready_c = r2; done_c = n2; swaps_c = s2; end
      3: begin dout_c = d3; ready_c = r3; done_c = n3; swaps_c = {2'b00, s3}; end
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int dep(input int s);
    return (s == 2) ? 5 : (s == 3) ? 2 : 8;
  endfunction

  function automatic int key(input int v, input bit sg);
    return (sg && v >= 128) ? v - 256 : v;
  endfunction

  // Reference: selection sort on plain ints, returns exchange count
  function automatic int model(input int n, input bit d, input bit sg,
                               input int src[8], output int dst[8]);
    int sw = 0;
    dst = src;
    for (int a = 0; a < n - 1; a++) begin
      int jm = a;
      for (int b = a + 1; b < n; b++) begin
        if (d ? key(dst[b], sg) > key(dst[jm], sg)
              : key(dst[b], sg) < key(dst[jm], sg))
          jm = b;
      end
      if (jm != a) begin
        int t = dst[a];
        dst[a] = dst[jm];
        dst[jm] = t;
        sw++;
      end
    end
    return sw;
  endfunction

  task automatic load(input int n, input int v[8]);
    for (int k = 0; k < n; k++) begin
      addr = 3'(k); datain = 8'(v[k]); wr = 1'b1;
      tick;
    end
    wr = 1'b0;
  endtask

  task automatic readback(input int n, input int e[8]);
    for (int k = 0; k < n; k++) begin
      addr = 3'(k);
      tick;
      chk($sformatf("rd%0d_s%0d", k, sel), dout_c, e[k]);
    end
    chk("no_done_on_host", done_c, 0);
  endtask

  task automatic run_sort(input int n, input bit d, input bit poke,
                          input bit both);
    int  cyc = 0;
    int  pulses = 0;
    bit  seen = 0;
    desc = d; start = 1'b1;
    wr = both; addr = 3'd1; datain = 8'h5A;
    tick;
    start = 1'b0; wr = 1'b0; desc = 1'b0;
    chk("busy_ready", ready_c, 0);
    while (!seen && cyc < n * n + 4 * n) begin
      if (poke && cyc == 2) begin
        wr = 1'b1; start = 1'b1; addr = 3'd0; datain = 8'hAA;
      end else begin
        wr = 1'b0; start = 1'b0;
      end
      tick;
      cyc++;
      if (done_c) begin seen = 1; pulses++; end
    end
    wr = 1'b0; start = 1'b0;
    chk("done_seen", seen, 1);
    chk("ready_at_done", ready_c, 1);
    tick;
    if (done_c) pulses++;
    chk("done_once", pulses, 1);
  endtask

  task automatic full(input int s, input bit d, input int v[8],
                      input bit poke, input bit both);
    int n;
    int e[8];
    int es;
    sel = s;
    n = dep(s);
    load(n, v);
    es = model(n, d, s == 1, v, e);
    run_sort(n, d, poke, both);
    chk($sformatf("swaps_s%0d", s), swaps_c, es);
    readback(n, e);
  endtask

  initial begin
    int v[8];
    int e[8];
    tick;
    chk("rst_ready", ready_c, 1);
    chk("rst_done", done_c, 0);
    chk("rst_swaps", swaps_c, 0);
    chk("rst_dout", dout_c, 0);
    @(negedge clk);
    nrst = 1'b1;

    v = '{7, 6, 5, 4, 3, 2, 1, 0};
    full(0, 0, v, 0, 0);
    chk("r36_swaps", swaps_c, 4);
    full(0, 1, v, 0, 0);
    chk("r37_swaps", swaps_c, 0);

    v = '{'h80, 'h7F, 'hFF, 'h00, 'h01, 'hFE, 'h10, 'h81};
    full(1, 0, v, 0, 0);
    e = '{'h80, 'h81, 'hFE, 'hFF, 'h00, 'h01, 'h10, 'h7F};
    readback(8, e);

    v = '{3, 1, 3, 1, 2, 2, 0, 0};
    full(0, 0, v, 1, 0);
    e = '{0, 0, 1, 1, 2, 2, 3, 3};
    readback(8, e);
    full(0, 1, v, 0, 1);

    v = '{9, 4, 200, 4, 1, 0, 0, 0};
    full(2, 0, v, 0, 0);
    v = '{5, 2, 0, 0, 0, 0, 0, 0};
    full(3, 0, v, 0, 0);
    full(3, 1, v, 0, 0);

    for (int r = 0; r < 16; r++) begin
      int hi = (r % 3 == 0) ? 3 : 255;
      for (int k = 0; k < 8; k++) v[k] = int'($urandom_range(0, hi));
      full(r % 4, 1'($urandom_range(0, 1)), v, r % 5 == 1, r % 7 == 2);
    end

    sel = 0;
    for (int k = 0; k < 8; k++) v[k] = int'($urandom_range(0, 255));
    load(8, v);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    nrst = 1'b0;
    #1;
    chk("abort_ready", ready_c, 1);
    chk("abort_swaps", swaps_c, 0);
    chk("abort_done", done_c, 0);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 8; k++) v[k] = int'($urandom_range(0, 255));
    full(0, 0, v, 0, 0);
    full(2, 1, v, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
